// File: rtl/ar_rr_arbiter_pkg.sv
// Shared AXI definitions for the AR-channel arbiter: payload width defaults,
// slave-side ID prefix width and the arbiter FSM state type.
package ar_rr_arbiter_pkg;

    localparam int AXI_ID_BITS        = 4;
    localparam int AXI_ADDR_BITS      = 32;
    localparam int AXI_LEN_BITS       = 4;
    localparam int AXI_SIZE_BITS      = 3;
    localparam int AXI_BURST_BITS     = 2;
    localparam int AXI_ID_PREFIX_BITS = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } ar_state_e;

endpackage

// File: rtl/ar_rr_arbiter_rr_pick.sv
// Priority search: first requester at or after ptr (with wrap) when rr_en is
// set, otherwise the lowest-indexed requester.
module rr_pick #(
    parameter int NUM_M = 2,
    parameter int IDX_W = 1
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_en,
    output logic [NUM_M-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0]   cand;
    logic [IDX_W:0]   base;
    logic             found;

    always_comb begin
        cand   = '0;
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        base   = rr_en ? {1'b0, ptr} : '0;
        for (int i = 0; i < NUM_M; i++) begin
            // ptr is always below NUM_M, so one conditional subtract is a full modulo
            cand = base + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(NUM_M))
                cand = cand - (IDX_W + 1)'(NUM_M);
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
        if (found)
            onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/ar_rr_arbiter.sv
// AXI AR-channel arbiter: NUM_M masters share one slave AR port, one transfer
// per grant, with the master index prepended to the slave-side ARID.
module ar_rr_arbiter
    import ar_rr_arbiter_pkg::*;
#(
    parameter int NUM_M     = 2,
    parameter int ID_BITS   = AXI_ID_BITS,
    parameter int ADDR_BITS = AXI_ADDR_BITS,
    parameter int LEN_BITS  = AXI_LEN_BITS,
    parameter int SIZE_BITS = AXI_SIZE_BITS,
    parameter int RR_EN     = 1
) (
    input  logic                                  ACLK,
    input  logic                                  ARESETn,
    input  logic [NUM_M*ID_BITS-1:0]              ARID_M,
    input  logic [NUM_M*ADDR_BITS-1:0]            ARADDR_M,
    input  logic [NUM_M*LEN_BITS-1:0]             ARLEN_M,
    input  logic [NUM_M*SIZE_BITS-1:0]            ARSIZE_M,
    input  logic [NUM_M*AXI_BURST_BITS-1:0]       ARBURST_M,
    input  logic [NUM_M-1:0]                      ARVALID_M,
    output logic [NUM_M-1:0]                      ARREADY_M,
    output logic [ID_BITS+AXI_ID_PREFIX_BITS-1:0] ARID_S,
    output logic [ADDR_BITS-1:0]                  ARADDR_S,
    output logic [LEN_BITS-1:0]                   ARLEN_S,
    output logic [SIZE_BITS-1:0]                  ARSIZE_S,
    output logic [AXI_BURST_BITS-1:0]             ARBURST_S,
    output logic                                  ARVALID_S,
    input  logic                                  ARREADY_S,
    output logic [NUM_M-1:0]                      GNT
);

    localparam int IDX_W = $clog2(NUM_M);

    ar_state_e          state, state_nxt;
    logic [IDX_W-1:0]   gidx, gidx_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [NUM_M-1:0]   gnt_q, gnt_nxt;
    logic [NUM_M-1:0]   pick_onehot;
    logic [IDX_W-1:0]   pick_idx;

    logic [ID_BITS-1:0]        sel_id;
    logic [ADDR_BITS-1:0]      sel_addr;
    logic [LEN_BITS-1:0]       sel_len;
    logic [SIZE_BITS-1:0]      sel_size;
    logic [AXI_BURST_BITS-1:0] sel_burst;
    logic                      sel_valid;
    logic                      hs;

    rr_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (ARVALID_M),
        .ptr    (ptr),
        .rr_en  (RR_EN != 0),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // Payload select driven by the registered grant index
    always_comb begin
        sel_id    = '0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        sel_valid = 1'b0;
        for (int m = 0; m < NUM_M; m++) begin
            if (gidx == IDX_W'(m)) begin
                sel_id    = ARID_M[m*ID_BITS +: ID_BITS];
                sel_addr  = ARADDR_M[m*ADDR_BITS +: ADDR_BITS];
                sel_len   = ARLEN_M[m*LEN_BITS +: LEN_BITS];
                sel_size  = ARSIZE_M[m*SIZE_BITS +: SIZE_BITS];
                sel_burst = ARBURST_M[m*AXI_BURST_BITS +: AXI_BURST_BITS];
                sel_valid = ARVALID_M[m];
            end
        end
    end

    assign hs = (state == ST_GRANT) && sel_valid && ARREADY_S;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= ST_IDLE;
            gidx  <= '0;
            ptr   <= '0;
            gnt_q <= '0;
        end else begin
            state <= state_nxt;
            gidx  <= gidx_nxt;
            ptr   <= ptr_nxt;
            gnt_q <= gnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gidx_nxt  = gidx;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt_q;
        ARVALID_S = 1'b0;
        ARREADY_M = '0;
        GNT       = '0;
        ARID_S    = '0;
        ARADDR_S  = '0;
        ARLEN_S   = '0;
        ARSIZE_S  = '0;
        ARBURST_S = '0;
        case (state)
            ST_IDLE: begin
                if (|ARVALID_M) begin
                    state_nxt = ST_GRANT;
                    gidx_nxt  = pick_idx;
                    gnt_nxt   = pick_onehot;
                end
            end
            ST_GRANT: begin
                ARVALID_S = sel_valid;
                ARREADY_M = gnt_q & {NUM_M{ARREADY_S}};
                GNT       = gnt_q;
                ARID_S    = {AXI_ID_PREFIX_BITS'(gidx), sel_id};
                ARADDR_S  = sel_addr;
                ARLEN_S   = sel_len;
                ARSIZE_S  = sel_size;
                ARBURST_S = sel_burst;
                if (hs) begin
                    state_nxt = ST_IDLE;
                    ptr_nxt   = (gidx == IDX_W'(NUM_M - 1)) ? '0 : gidx + IDX_W'(1);
                end else if (!sel_valid) begin
                    // abandoned request: release the grant without advancing priority
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ar_rr_arbiter.sv
// Directed bench for ar_rr_arbiter: round-robin instance checked through a
// grant scoreboard, plus a fixed-priority instance sharing the same inputs.
module tb_ar_rr_arbiter;

    localparam int NM  = 3;
    localparam int IDB = 4;
    localparam int AB  = 32;
    localparam int LB  = 4;
    localparam int SB  = 3;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [NM*IDB-1:0] arid_m;
    logic [NM*AB-1:0]  araddr_m;
    logic [NM*LB-1:0]  arlen_m;
    logic [NM*SB-1:0]  arsize_m;
    logic [NM*2-1:0]   arburst_m;
    logic [NM-1:0]     arvalid_m;
    logic              arready_s;

    logic [NM-1:0]  arready_m, b_arready_m;
    logic [IDB+3:0] arid_s, b_arid_s;
    logic [AB-1:0]  araddr_s, b_araddr_s;
    logic [LB-1:0]  arlen_s, b_arlen_s;
    logic [SB-1:0]  arsize_s, b_arsize_s;
    logic [1:0]     arburst_s, b_arburst_s;
    logic           arvalid_s, b_arvalid_s;
    logic [NM-1:0]  gnt, b_gnt;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int mon_m;
    int nb;
    logic [7:0] pat;

    ar_rr_arbiter #(.NUM_M(NM), .ID_BITS(IDB), .ADDR_BITS(AB), .LEN_BITS(LB),
                    .SIZE_BITS(SB), .RR_EN(1)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_M(arid_m), .ARADDR_M(araddr_m), .ARLEN_M(arlen_m),
        .ARSIZE_M(arsize_m), .ARBURST_M(arburst_m), .ARVALID_M(arvalid_m),
        .ARREADY_M(arready_m), .ARID_S(arid_s), .ARADDR_S(araddr_s),
        .ARLEN_S(arlen_s), .ARSIZE_S(arsize_s), .ARBURST_S(arburst_s),
        .ARVALID_S(arvalid_s), .ARREADY_S(arready_s), .GNT(gnt)
    );

    ar_rr_arbiter #(.NUM_M(NM), .ID_BITS(IDB), .ADDR_BITS(AB), .LEN_BITS(LB),
                    .SIZE_BITS(SB), .RR_EN(0)) dut_fixed (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_M(arid_m), .ARADDR_M(araddr_m), .ARLEN_M(arlen_m),
        .ARSIZE_M(arsize_m), .ARBURST_M(arburst_m), .ARVALID_M(arvalid_m),
        .ARREADY_M(b_arready_m), .ARID_S(b_arid_s), .ARADDR_S(b_araddr_s),
        .ARLEN_S(b_arlen_s), .ARSIZE_S(b_arsize_s), .ARBURST_S(b_arburst_s),
        .ARVALID_S(b_arvalid_s), .ARREADY_S(arready_s), .GNT(b_gnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every handshake on the round-robin instance must match the next queued grant
    always @(negedge ACLK) begin
        if (ARESETn && arvalid_s && arready_s) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed_gnt=%0h expected=none", gnt);
            end
            if (exp_q.size() != 0) begin
                mon_m = exp_q.pop_front();
                chk("sb_gnt", 64'(gnt), 64'(1) << mon_m);
                chk("sb_arid", 64'(arid_s), {56'd0, 4'(mon_m), 4'(3 + mon_m)});
                chk("sb_araddr", 64'(araddr_s), 64'(32'h1000 + mon_m * 32'h100));
                chk("sb_arlen", 64'(arlen_s), 64'(mon_m));
                chk("sb_arburst", 64'(arburst_s), 64'd1);
            end
        end
    end

    initial begin
        for (int m = 0; m < NM; m++) begin
            arid_m[m*IDB +: IDB]  = IDB'(3 + m);
            araddr_m[m*AB +: AB]  = 32'h1000 + 32'(m) * 32'h100;
            arlen_m[m*LB +: LB]   = LB'(m);
            arsize_m[m*SB +: SB]  = SB'(m);
            arburst_m[m*2 +: 2]   = 2'b01;
        end
        arvalid_m = '0;
        arready_s = 1'b0;

        // reset state
        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_valid", 64'(arvalid_s), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_ardy", 64'(arready_m), 64'd0);
        ARESETn = 1'b1;

        // single request from M0, one-cycle latency
        arvalid_m = 3'b001;
        @(negedge ACLK);
        chk("idle_no_comb_valid", 64'(arvalid_s), 64'd0);
        chk("idle_gnt", 64'(gnt), 64'd0);
        @(posedge ACLK); #1;
        chk("m0_valid", 64'(arvalid_s), 64'd1);
        chk("m0_arid", 64'(arid_s), 64'h03);
        chk("m0_araddr", 64'(araddr_s), 64'h1000);
        chk("m0_gnt", 64'(gnt), 64'b001);
        chk("m0_ardy_stalled", 64'(arready_m), 64'd0);
        arready_s = 1'b1;
        exp_q.push_back(0);
        @(negedge ACLK);
        chk("m0_ardy", 64'(arready_m), 64'b001);
        @(posedge ACLK); #1;
        arvalid_m = '0;
        chk("m0_back_idle", 64'(arvalid_s), 64'd0);

        // M0 and M1 continuous: alternate with an IDLE cycle between grants
        arvalid_m = 3'b011;
        exp_q.push_back(1); exp_q.push_back(0);
        exp_q.push_back(1); exp_q.push_back(0);
        for (int i = 0; i < 8; i++) begin
            @(negedge ACLK);
            pat[i] = arvalid_s;
        end
        chk("alt_pattern", 64'(pat), 64'b10101010);
        @(posedge ACLK); #1;
        arvalid_m = '0;
        arready_s = 1'b0;

        // M2 granted, slave stalls, M0 requests meanwhile
        arvalid_m = 3'b100;
        @(posedge ACLK); #1;
        arvalid_m = 3'b101;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("stall_gnt", 64'(gnt), 64'b100);
            chk("stall_ardy", 64'(arready_m), 64'd0);
            chk("stall_valid", 64'(arvalid_s), 64'd1);
            @(posedge ACLK); #1;
        end
        arready_s = 1'b1;
        exp_q.push_back(2);
        @(negedge ACLK);
        chk("stall_release_ardy", 64'(arready_m), 64'b100);
        @(posedge ACLK); #1;
        // pointer wraps 2 -> 0 on a non-power-of-2 master count
        arvalid_m = 3'b011;
        exp_q.push_back(0);
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        arvalid_m = '0;
        arready_s = 1'b0;

        // granted master withdraws before handshake
        arvalid_m = 3'b010;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("drop_gnt", 64'(gnt), 64'b010);
        @(posedge ACLK); #1;
        arvalid_m = 3'b000;
        @(negedge ACLK);
        chk("drop_valid", 64'(arvalid_s), 64'd0);
        @(posedge ACLK); #1;
        chk("drop_idle_gnt", 64'(gnt), 64'd0);
        arvalid_m = 3'b011;
        arready_s = 1'b1;
        exp_q.push_back(1);
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        arvalid_m = '0;
        arready_s = 1'b0;

        // reset asserted mid-GRANT
        arvalid_m = 3'b111;
        @(posedge ACLK); #1;
        chk("rst_pre_gnt", 64'(gnt), 64'b100);
        @(negedge ACLK); #1;
        ARESETn = 1'b0;
        #1;
        chk("midrst_valid", 64'(arvalid_s), 64'd0);
        chk("midrst_gnt", 64'(gnt), 64'd0);
        chk("midrst_ardy", 64'(arready_m), 64'd0);
        chk("midrst_arid", 64'(arid_s), 64'd0);
        chk("midrst_araddr", 64'(araddr_s), 64'd0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        arready_s = 1'b1;
        exp_q.push_back(0);
        @(posedge ACLK); #1;
        chk("post_rst_first_arb", 64'(arvalid_s), 64'd1);
        @(posedge ACLK); #1;
        arvalid_m = '0;
        arready_s = 1'b0;
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;

        // M1 and M2 continuous: fixed priority always picks M1, RR alternates
        arvalid_m = 3'b110;
        arready_s = 1'b1;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1);
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            if (b_arvalid_s) begin
                nb++;
                chk("fixed_gnt", 64'(b_gnt), 64'b010);
                chk("fixed_prefix", 64'(b_arid_s[7:4]), 64'h1);
            end
        end
        chk("fixed_count", 64'(nb), 64'd3);
        @(posedge ACLK); #1;
        arvalid_m = '0;
        arready_s = 1'b0;
        @(posedge ACLK); #1;

        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ar_rr_arbiter.md
AR_RR_ARBITER -- requirements
Module: ar_rr_arbiter

Interface
REQ-001 Parameter NUM_M, default 2: number of AXI masters sharing one AR channel, legal range 2..16.
REQ-002 Parameter ID_BITS, default 4: master-side ARID width.
REQ-003 Parameter ADDR_BITS, default 32; LEN_BITS, default 4; SIZE_BITS, default 3: AR payload widths.
REQ-004 Parameter RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with master 0 highest.
REQ-005 ACLK  input  1: single clock; all state updates on the rising edge.
REQ-006 ARESETn  input  1: asynchronous, active-low reset.
REQ-007 ARID_M  input  NUM_M*ID_BITS: per-master ARID, master m in slice m.
REQ-008 ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M  input  NUM_M*(ADDR_BITS, LEN_BITS, SIZE_BITS, 2): per-master payload, packed the same way.
REQ-009 ARVALID_M  input  NUM_M: per-master valid.
REQ-010 ARREADY_M  output  NUM_M: per-master ready.
REQ-011 ARID_S  output  ID_BITS+4: slave-side ID, formed as {master index zero-extended to 4 bits, ARID}.
REQ-012 ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  output  payload widths: slave-side payload.
REQ-013 ARVALID_S  output  1: slave-side valid.
REQ-014 ARREADY_S  input  1: slave-side ready.
REQ-015 GNT  output  NUM_M: one-hot current grant, for R-channel routing and debug.

Function
REQ-016 The FSM SHALL have two states: IDLE and GRANT.
REQ-017 In IDLE with any ARVALID_M high, the arbiter SHALL choose a winner, register its index and enter GRANT on the next edge.
REQ-018 With RR_EN=1, the winner SHALL be the first requester at or after pointer PTR, searching upward with wrap from NUM_M-1 to 0.
REQ-019 With RR_EN=0, the winner SHALL be the lowest-indexed requester, and PTR SHALL be ignored.
REQ-020 In IDLE, ARVALID_S, ARREADY_M, GNT and all ARx_S payload outputs SHALL be 0.
REQ-021 In GRANT, all ARx_S outputs SHALL combinationally mirror the granted master's inputs, and ARVALID_S SHALL equal that master's ARVALID_M.
REQ-022 In GRANT, ARREADY_M[g] SHALL equal ARREADY_S for the granted master g, and be 0 for all other masters.
REQ-023 Request-to-ARVALID_S latency SHALL be exactly 1 cycle; there SHALL be no combinational path from ARVALID_M to ARVALID_S in IDLE.
REQ-024 On handshake (ARVALID_S and ARREADY_S both high in GRANT), the FSM SHALL return to IDLE, and PTR SHALL become (g+1) mod NUM_M.
REQ-025 Back-to-back grants SHALL therefore be separated by one IDLE cycle, giving a peak throughput of one AR transfer per 2 cycles.
REQ-026 If the granted master drops ARVALID in GRANT without a handshake, the FSM SHALL return to IDLE with PTR unchanged.
REQ-027 The grant SHALL remain locked while the slave stalls; new requests from other masters SHALL NOT change g.
REQ-028 The PTR wrap SHALL be a modulo-NUM_M computation, correct for NUM_M values that are not a power of 2.

Reset
REQ-029 Asserting ARESETn low SHALL immediately force state IDLE, PTR=0, g=0, and all outputs to 0, including mid-GRANT.
REQ-030 After reset release, the first arbitration SHALL occur on the first rising edge on which ARESETn is high.

Structure
REQ-031 The ID prefix width (4) and the FSM state enum SHALL live in the shared AXI package, alongside the existing AXI_*_BITS defines.
REQ-032 The priority search SHALL be one sub-module, rr_pick, with inputs (req vector, PTR, RR_EN) and outputs (one-hot winner, index).
REQ-033 The muxing SHALL be index-driven over generate/loop code; it SHALL NOT be written as per-master case items.

Verification
REQ-034 Reset, then M0 requests alone with ARID=4'h3 and ARADDR=0x1000 -> 1 cycle later ARVALID_S=1, ARID_S=8'h03, ARADDR_S=0x1000.
REQ-035 M0 and M1 request continuously, NUM_M=2, ARREADY_S=1 -> grants alternate M0,M1,M0,M1, each ARVALID_S pulse separated by one IDLE cycle.
REQ-036 NUM_M=3, RR_EN=0, M1 and M2 request continuously -> M1 wins every grant; ARID_S[7:4]=4'h1.
REQ-037 M2 is granted, ARREADY_S is held low 5 cycles, and M0 raises ARVALID -> GNT stays 3'b100 and ARREADY_M[0] stays 0 until the handshake.
REQ-038 ARESETn is pulsed low mid-GRANT -> outputs are 0 within the same cycle; after release, PTR=0, so M0 wins when all masters request.
REQ-039 The granted master drops ARVALID before ARREADY_S -> the FSM returns to IDLE and the same master wins again if it re-requests.
